alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, meaning command-queue entries, power of two, >= 2, used only with ALU_DRV_FIFO_EN.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  power request; drives alu_on.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; transfer when both are high at a clock edge.
REQ-006 cmd_op  input  3  0=AND, 1=OR, 2=NOT, 3=XOR, 4=ADD, 5=SUB, 6=MULT, 7=illegal.
REQ-007 cmd_mode  input  2  0=LOAD (accumulator from cmd_a), 1=CHAIN (accumulator keeps previous result), 2=RESET, 3=illegal.
REQ-008 cmd_a, cmd_b  input  8  operands.
REQ-009 alu_on  output  1  ALU on/off.
REQ-010 alu_in_sel  output  3  one-hot: 100 persist, 010 load, 001 reset.
REQ-011 alu_out_sel  output  7  one-hot, MSB..LSB = AND, OR, NOT, XOR, ADD, SUB, MULT.
REQ-012 alu_num1, alu_num2  output  8  ALU operands.
REQ-013 alu_result  input  8  ALU output value.
REQ-014 alu_state  input  2  ALU state: 00 off, 01 ready, 10 run, 11 run_error.
REQ-015 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-016 rsp_data  output  8  captured result.
REQ-017 rsp_err  output  1  overflow or illegal command.

Function
REQ-018 The FSM SHALL have states OFF, IDLE, ISSUE, CAPTURE and RESP.
REQ-019 OFF: alu_on=0 and cmd_ready=0; go to IDLE when enable=1.
REQ-020 IDLE: alu_on=1; on a queued command go to ISSUE, else stay; enable=0 goes to OFF.
REQ-021 ISSUE lasts exactly one cycle and drives:
- alu_in_sel = 010 for LOAD, 100 for CHAIN, 001 for RESET.
- alu_num1 = cmd_a; alu_num2 = cmd_b.
- alu_out_sel = one-hot of cmd_op.
REQ-022 Outside ISSUE: alu_in_sel=100, alu_out_sel=1000000, alu_num1 = alu_num2 = 0.
REQ-023 CAPTURE lasts exactly one cycle:
- register rsp_data=alu_result and rsp_err=(alu_state==11);
- go to RESP.
REQ-024 Command-accept-to-rsp_valid latency SHALL be 3 cycles with an empty queue.
REQ-025 RESP: hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1, then go to IDLE (or OFF if enable=0).
REQ-026 Illegal cmd_op or cmd_mode: skip ISSUE and CAPTURE, go straight to RESP with rsp_data=0 and rsp_err=1, leaving ALU inputs idle.
REQ-027 RESET mode: drive alu_out_sel for AND and report rsp_data=alu_result (expected 0) with rsp_err=0.
REQ-028 enable falling mid-command: finish through RESP, then go to OFF; no command is dropped.
REQ-029 Accept and dequeue in the same cycle SHALL be allowed and keep occupancy unchanged.

Reset
REQ-030 While rst=0, outputs SHALL be:
- state=OFF, alu_on=0, alu_in_sel=100, alu_out_sel=1000000;
- alu_num1 = alu_num2 = 0;
- cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-031 rst asserted mid-operation SHALL discard queued and in-flight commands and any pending response.

Configuration
REQ-032 With ALU_DRV_FIFO_EN defined:
- commands SHALL queue in a FIFO_DEPTH-entry FIFO;
- cmd_ready = not full and state != OFF.
REQ-033 Without ALU_DRV_FIFO_EN:
- a single holding register SHALL be used;
- cmd_ready=1 only in IDLE with the register empty.

Structure
REQ-034 Package alu_pkg SHALL hold:
- ALU state codes 00/01/10/11;
- in_sel codes;
- cmd_op and cmd_mode encodings;
- the op-to-one-hot mapping;
- the driver FSM state encoding.
REQ-035 The queue SHALL be sub-module alu_cmd_fifo, with wrapping pointers and an occupancy count (full at FIFO_DEPTH, empty at 0).

Verification
REQ-036 Reset then enable=1: cmd LOAD ADD a=5 b=3 -> ISSUE shows in_sel=010 and out_sel=0000100; rsp_data=8, rsp_err=0 three cycles after accept.
REQ-037 CHAIN SUB b=2 after REQ-036 -> in_sel=100; rsp_data=6.
REQ-038 LOAD MULT a=20 b=20 with the ALU model reporting alu_state=11 -> rsp_err=1.
REQ-039 cmd_op=7 -> rsp_valid with rsp_data=0 and rsp_err=1; alu_in_sel stays 100 throughout.
REQ-040 With ALU_DRV_FIFO_EN: push 5 commands while rsp_ready=0 -> cmd_ready drops after 4 queued; results return in order once rsp_ready=1.
REQ-041 rst=0 while in RESP -> rsp_valid=0 immediately; no stale response after rst and enable return high.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU driver: ALU status codes, operand-select codes,
// command fields, the driver FSM states and the op-to-one-hot mapping.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_OFF       = 2'b00,
    ALU_READY     = 2'b01,
    ALU_RUN       = 2'b10,
    ALU_RUN_ERROR = 2'b11
  } aluState_e;

  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_RESET   = 3'b001;

  localparam logic [6:0] OUT_SEL_IDLE   = 7'b1000000;

  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADD, OP_SUB, OP_MULT, OP_ILLEGAL
  } cmdOp_e;

  typedef enum logic [1:0] {
    MODE_LOAD, MODE_CHAIN, MODE_RESET, MODE_ILLEGAL
  } cmdMode_e;

  typedef enum logic [2:0] {
    DRV_OFF, DRV_IDLE, DRV_ISSUE, DRV_CAPTURE, DRV_RESP
  } drvState_e;

  typedef struct packed {
    cmdOp_e     op;
    cmdMode_e   mode;
    logic [7:0] a;
    logic [7:0] b;
  } aluCmd_t;

  // AND sits in the MSB, so the one-hot is the MSB shifted right by the opcode.
  function automatic logic [6:0] opOneHot(cmdOp_e op);
    return OUT_SEL_IDLE >> op;
  endfunction

  function automatic logic [2:0] inSelCode(cmdMode_e mode);
    case (mode)
      MODE_LOAD:  return IN_SEL_LOAD;
      MODE_RESET: return IN_SEL_RESET;
      default:    return IN_SEL_PERSIST;
    endcase
  endfunction

  function automatic logic cmdIsLegal(aluCmd_t cmd);
    return (cmd.op != OP_ILLEGAL) && (cmd.mode != MODE_ILLEGAL);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for the ALU driver: circular buffer with wrapping pointers and
// an occupancy count; push and pop in the same cycle keep the count unchanged.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  aluCmd_t wrData,
  output aluCmd_t rdData,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  aluCmd_t       mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          doPush;
  logic          doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // NOTE: the storage array has no reset; entries are only read when count
  // says they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdData = mem[rdPtr];
  assign full   = (count == (PW + 1)'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/alu_driver.sv
// Command/response front end for a multi-function ALU. Define ALU_DRV_FIFO_EN
// to queue commands in a FIFO_DEPTH-entry FIFO instead of one holding register.
module alu_driver
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       alu_on,
  output logic [2:0] alu_in_sel,
  output logic [6:0] alu_out_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  input  logic [7:0] alu_result,
  input  logic [1:0] alu_state,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("alu_driver: FIFO_DEPTH must be a power of two >= 2");
  end

  drvState_e state;
  drvState_e nextState;
  aluCmd_t   inCmd;
  aluCmd_t   headCmd;
  aluCmd_t   curCmd;
  logic      headValid;
  logic      push;
  logic      pop;

  assign inCmd = '{op: cmdOp_e'(cmd_op), mode: cmdMode_e'(cmd_mode), a: cmd_a, b: cmd_b};
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state == DRV_IDLE) && enable && headValid;

`ifdef ALU_DRV_FIFO_EN
  logic fifoFull;
  logic fifoEmpty;

  alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) uCmdFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wrData (inCmd),
    .rdData (headCmd),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign headValid = !fifoEmpty;
  assign cmd_ready = !fifoFull && (state != DRV_OFF);
`else
  logic    holdValid;
  aluCmd_t holdCmd;

  // Accept and dispatch never coincide here: acceptance needs the register empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdValid <= 1'b0;
      holdCmd   <= '0;
    end else if (push) begin
      holdValid <= 1'b1;
      holdCmd   <= inCmd;
    end else if (pop) begin
      holdValid <= 1'b0;
    end
  end

  assign headValid = holdValid;
  assign headCmd   = holdCmd;
  assign cmd_ready = (state == DRV_IDLE) && !holdValid;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DRV_OFF;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      DRV_OFF:     if (enable) nextState = DRV_IDLE;
      DRV_IDLE: begin
        if (!enable)        nextState = DRV_OFF;
        else if (headValid) nextState = cmdIsLegal(headCmd) ? DRV_ISSUE : DRV_RESP;
      end
      DRV_ISSUE:   nextState = DRV_CAPTURE;
      DRV_CAPTURE: nextState = DRV_RESP;
      DRV_RESP:    if (rsp_ready) nextState = enable ? DRV_IDLE : DRV_OFF;
      default:     nextState = DRV_OFF;
    endcase
  end

  // Illegal commands are answered directly at dispatch; legal ones in CAPTURE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curCmd   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (pop) curCmd <= headCmd;
      if (state == DRV_CAPTURE) begin
        rsp_data <= alu_result;
        rsp_err  <= (curCmd.mode != MODE_RESET) && (alu_state == ALU_RUN_ERROR);
      end else if (pop && !cmdIsLegal(headCmd)) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  // NOTE: every output gets its idle value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_on      = (state != DRV_OFF);
    rsp_valid   = (state == DRV_RESP);
    alu_in_sel  = IN_SEL_PERSIST;
    alu_out_sel = OUT_SEL_IDLE;
    alu_num1    = '0;
    alu_num2    = '0;
    if (state == DRV_ISSUE) begin
      alu_in_sel  = inSelCode(curCmd.mode);
      alu_out_sel = (curCmd.mode == MODE_RESET) ? opOneHot(OP_AND) : opOneHot(curCmd.op);
      alu_num1    = curCmd.a;
      alu_num2    = curCmd.b;
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: a pin-level ALU model answers the driver,
// and a command-level reference model predicts every response.
module tb_alu_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_mode = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [7:0] alu_result;
  logic [1:0] alu_state;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;

  int compared = 0;
  int mismatched = 0;
  int refPrev = 0;

  always #5 clk = ~clk;

  alu_driver #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_mode    (cmd_mode),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_on      (alu_on),
    .alu_in_sel  (alu_in_sel),
    .alu_out_sel (alu_out_sel),
    .alu_num1    (alu_num1),
    .alu_num2    (alu_num2),
    .alu_result  (alu_result),
    .alu_state   (alu_state),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // ALU model: executes whatever the driver presents, except the all-idle pin pattern.
  function automatic logic [9:0] aluCompute(logic [2:0] inSel, logic [6:0] outSel,
                                            logic [7:0] n1, logic [7:0] n2, logic [7:0] acc);
    int x;
    int full;
    x = (inSel == 3'b010) ? int'(n1) : (inSel == 3'b001) ? 0 : int'(acc);
    case (outSel)
      7'b1000000: full = x & int'(n2);
      7'b0100000: full = x | int'(n2);
      7'b0010000: full = (~x) & 255;
      7'b0001000: full = x ^ int'(n2);
      7'b0000100: full = x + int'(n2);
      7'b0000010: full = x - int'(n2);
      7'b0000001: full = x * int'(n2);
      default:    full = 0;
    endcase
    return {((full > 255) || (full < 0)) ? 2'b11 : 2'b10, full[7:0]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result <= '0;
      alu_state  <= 2'b00;
    end else if (!alu_on) begin
      alu_state <= 2'b00;
    end else if (alu_in_sel == 3'b100 && alu_out_sel == 7'b1000000 &&
                 alu_num1 == 8'd0 && alu_num2 == 8'd0) begin
      if (alu_state == 2'b00) alu_state <= 2'b01;
    end else begin
      {alu_state, alu_result} <= aluCompute(alu_in_sel, alu_out_sel, alu_num1, alu_num2, alu_result);
    end
  end

  // Reference: response of one command from its fields and the previous result.
  function automatic logic [8:0] refExec(int op, int mode, int a, int b, int prev);
    int x;
    int full;
    if (op == 7 || mode == 3) return {1'b1, 8'd0};
    if (mode == 2) return {1'b0, 8'd0};
    x = (mode == 0) ? a : prev;
    case (op)
      0:       full = x & b;
      1:       full = x | b;
      2:       full = 255 - x;
      3:       full = x ^ b;
      4:       full = x + b;
      5:       full = x - b;
      default: full = x * b;
    endcase
    return {(full > 255) || (full < 0), full[7:0]};
  endfunction

  // Called at a negedge; returns after the accepting posedge, at the next negedge.
  task automatic sendCmd(input int op, input int mode, input int a, input int b);
    bit ok;
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_mode  = 2'(mode);
    cmd_a     = 8'(a);
    cmd_b     = 8'(b);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    check("cmd_accepted", 32'(ok), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic runCmd(input int op, input int mode, input int a, input int b, input bit dropEn);
    logic [6:0] outTab [7];
    logic [8:0] exp;
    bit         legal;
    int         lat;
    outTab = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001};
    legal = (op != 7) && (mode != 3);
    exp = refExec(op, mode, a, b, refPrev);
    if (legal) refPrev = int'(exp[7:0]);
    sendCmd(op, mode, a, b);
    lat = -1;
    for (int k = 0; k <= 20 && lat < 0; k++) begin
      if (legal && k == 1) begin
        check("issue_in_sel", alu_in_sel, (mode == 0) ? 3'b010 : (mode == 1) ? 3'b100 : 3'b001);
        check("issue_out_sel", alu_out_sel, outTab[(mode == 2) ? 0 : op]);
        check("issue_num1", alu_num1, 32'(a));
        check("issue_num2", alu_num2, 32'(b));
        if (dropEn) enable = 1'b0;
      end
      if (!legal) check("illegal_in_sel", alu_in_sel, 3'b100);
      if (rsp_valid) lat = k;
      else @(negedge clk);
    end
    check("latency", 32'(lat), legal ? 32'd3 : 32'd1);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("rsp_valid_held", rsp_valid, 1'b1);
    check("rsp_data", rsp_data, exp[7:0]);
    check("rsp_err", rsp_err, exp[8]);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 1'b0);
    check("alu_on_after", alu_on, !dropEn);
    if (dropEn) begin
      enable = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    int op;
    int mode;
    int a;
    int b;
    bit seen;

    repeat (2) @(negedge clk);
    check("rst_alu_on", alu_on, 1'b0);
    check("rst_in_sel", alu_in_sel, 3'b100);
    check("rst_out_sel", alu_out_sel, 7'b1000000);
    check("rst_num1", alu_num1, 8'd0);
    check("rst_num2", alu_num2, 8'd0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", {rsp_err, rsp_data}, 9'd0);

    rst = 1'b1;
    @(negedge clk);
    check("off_alu_on", alu_on, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    check("idle_alu_on", alu_on, 1'b1);
    check("idle_cmd_ready", cmd_ready, 1'b1);

    runCmd(4, 0, 5, 3, 1'b0);     // LOAD ADD 5+3
    runCmd(5, 1, 0, 2, 1'b0);     // CHAIN SUB 2
    runCmd(6, 0, 20, 20, 1'b0);   // LOAD MULT overflow
    runCmd(7, 0, 9, 9, 1'b0);     // illegal op
    runCmd(3, 3, 9, 9, 1'b0);     // illegal mode
    runCmd(1, 2, 200, 77, 1'b0);  // RESET mode

    for (int n = 0; n < 30; n++) begin
      op   = $urandom_range(0, 7);
      mode = $urandom_range(0, 3);
      a    = $urandom_range(0, 255);
      b    = $urandom_range(0, 255);
      // CHAIN AND of 0,0 looks exactly like the idle pin pattern to the ALU.
      if (op == 0 && mode == 1 && a == 0 && b == 0) b = 1;
      runCmd(op, mode, a, b, 1'b0);
    end

    runCmd(4, 0, 100, 27, 1'b1);  // enable drops while in flight

`ifdef ALU_DRV_FIFO_EN
    begin
      int accepted;
      int expQ[$];
      accepted = 0;
      for (int i = 0; i < 8; i++) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_mode  = 2'd0;
        cmd_a     = 8'(10 * accepted + 1);
        cmd_b     = 8'(accepted);
        if (cmd_ready) begin
          expQ.push_back(11 * accepted + 1);
          accepted++;
        end
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("fifo_accepted", 32'(accepted), 32'd5);
      check("fifo_full_ready", cmd_ready, 1'b0);
      while (expQ.size() > 0) begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          if (rsp_valid) seen = 1'b1;
          else @(negedge clk);
        end
        check("fifo_rsp_seen", 32'(seen), 32'd1);
        check("fifo_rsp_data", rsp_data, 8'(expQ[0]));
        refPrev = expQ.pop_front();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
      end
    end
`endif

    sendCmd(1, 0, 15, 240);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("pre_reset_rsp", 32'(seen), 32'd1);
    rst = 1'b0;
    refPrev = 0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_alu_on", alu_on, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    check("mid_rst_rsp_data", {rsp_err, rsp_data}, 9'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 1'b0);
    end
    runCmd(3, 0, 8'hA5, 8'h0F, 1'b0);
    runCmd(2, 1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
